apb_arbiter_master: RTL
=======================

APB_ARBITER_MASTER -- requirements
Module: apb_arbiter_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of ACCESS cycles to wait for pready before the transfer is aborted with an error.
REQ-002 SHALL have parameter GPIO_BASE, default 20'h40000, matched against addr[31:12] to select the GPIO slave.
REQ-003 SHALL have parameter UART_BASE, default 20'h40001, matched against addr[31:12] to select the UART slave.
REQ-004 SHALL have ports pclk (in, 1, clock) and rst (in, 1, reset): one clock; reset is asynchronous and active-low.
REQ-005 SHALL have, for each requester N in {0,1}, the following ports:
- reqN_valid (in, 1): request pending.
- reqN_write (in, 1): 1 = write, 0 = read.
- reqN_addr (in, 32): transfer address.
- reqN_wdata (in, 32): write data.
- reqN_strb (in, 4): write byte strobes.
REQ-006 SHALL have, for each requester N, the following ports:
- reqN_ready (out, 1): single-cycle accept pulse.
- reqN_done (out, 1): single-cycle completion pulse.
- reqN_rdata (out, 32): read data.
- reqN_err (out, 1): error flag, valid with reqN_done.
REQ-007 SHALL drive the shared APB outputs paddr (32), pwrite (1), pwdata (32), pstrb (4) and penable (1).
REQ-008 SHALL have per-slave APB ports:
- psel_gpio and psel_uart (out, 1).
- pready_gpio and pready_uart (in, 1).
- prdata_gpio and prdata_uart (in, 32).
- pslverr_gpio and pslverr_uart (in, 1).

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, ACCESS and RESP.
REQ-010 In IDLE with at least one reqN_valid, SHALL grant round-robin, with priority going to the requester not granted last. On that edge it SHALL pulse reqN_ready, latch write/addr/wdata/strb, and decode the address.
REQ-011 Requesters SHALL hold request fields stable until reqN_ready. Fields are not sampled after the grant edge.
REQ-012 Decode hit SHALL move the FSM IDLE->SETUP: psel_x=1, penable=0, with paddr/pwrite/pwdata/pstrb driven from the latched request.
REQ-013 SETUP SHALL move to ACCESS unconditionally after one cycle: psel_x=1, penable=1.
REQ-014 In ACCESS, the FSM SHALL sample only the selected slave's pready. When pready=1, it SHALL capture that slave's prdata and pslverr and move to RESP.
REQ-015 Reads SHALL return the captured prdata on reqN_rdata. Writes SHALL return reqN_rdata=0.
REQ-016 An ACCESS cycle counter SHALL start at 0 on entry. If pready is still 0 when the counter reaches TIMEOUT-1, the FSM SHALL move to RESP with err=1 and rdata=0.
REQ-017 Decode miss (addr[31:12] matching neither base) SHALL move IDLE->RESP directly, with no psel asserted, err=1 and rdata=0.
REQ-018 In RESP, psel_* and penable SHALL be 0, and reqN_done SHALL pulse for exactly one cycle, only for the granted N. reqN_rdata and reqN_err SHALL hold until that requester's next done. The FSM SHALL then return to IDLE.
REQ-019 At most one psel_* SHALL be high in any cycle. penable SHALL never be high without psel.
REQ-020 Minimum latency from grant edge to done pulse SHALL be 3 cycles (IDLE->SETUP->ACCESS->RESP) when pready=1 on the first ACCESS cycle.
REQ-021 A new grant SHALL occur no earlier than the cycle after RESP. Back-to-back transfers SHALL therefore occupy 4 cycles each.
REQ-022 Deasserting reqN_valid before grant SHALL withdraw the request without side effects. Deasserting it after grant SHALL NOT abort the transfer.
REQ-023 pslverr from the slave SHALL be reported on reqN_err unchanged, and SHALL NOT cause a retry.

Reset
REQ-024 While rst=0, the FSM SHALL return to IDLE immediately, at any state including mid-transfer.
REQ-025 While rst=0, all outputs SHALL be 0, the ACCESS counter SHALL be 0, and the round-robin pointer SHALL be set so req0 wins the first simultaneous request.
REQ-026 No done pulse SHALL be issued for a transfer interrupted by reset.

Verification
REQ-027 Single GPIO write scenario:
- Stimulus: req0 write addr=0x40000008, wdata=1, pready_gpio tied 1.
- Required response: psel_gpio high 2 cycles, penable high 1 cycle, req0_done 3 cycles after req0_ready, req0_err=0.
REQ-028 Simultaneous requests scenario:
- Stimulus: req0 and req1 both valid from reset.
- Required response: grants in order req0, req1, req0, req1, each transfer 4 cycles apart.
REQ-029 UART read with wait states scenario:
- Stimulus: addr=0x40001000, pready_uart low 3 ACCESS cycles, prdata_uart=0xA5.
- Required response: reqN_rdata=0xA5 and done 6 cycles after grant.
REQ-030 Timeout scenario:
- Stimulus: pready_gpio stuck 0 with TIMEOUT=16.
- Required response: done with err=1 and rdata=0 after 16 ACCESS cycles, then psel_gpio=0.
REQ-031 Decode miss scenario:
- Stimulus: addr=0x50000000.
- Required response: no psel asserted, done 1 cycle after grant, err=1.
REQ-032 Reset-in-ACCESS scenario:
- Stimulus: rst=0 asserted during ACCESS.
- Required response: all outputs 0 asynchronously, no done pulse, next request is granted normally after rst=1.

Source files
------------

// File: rtl/apb_arbiter_master.sv
// Round-robin arbiter for two requesters in front of an APB master with a GPIO and a UART slave.
// Each grant runs one complete APB transfer (or reports a decode-miss error) before the next grant.
module apb_arbiter_master #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [19:0] GPIO_BASE = 20'h40000,
    parameter logic [19:0] UART_BASE = 20'h40001
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_strb,
    output logic        req0_ready,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_strb,
    output logic        req1_ready,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic [31:0] paddr,
    output logic        pwrite,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    output logic        penable,
    output logic        psel_gpio,
    output logic        psel_uart,
    input  logic        pready_gpio,
    input  logic        pready_uart,
    input  logic [31:0] prdata_gpio,
    input  logic [31:0] prdata_uart,
    input  logic        pslverr_gpio,
    input  logic        pslverr_uart,
    output logic [1:0]  dbg_state
);

    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, last_q;
    logic          sel_gpio_q, sel_uart_q;
    logic [CW-1:0] cnt_q;

    logic          req_any, gnt_idx, grant;
    logic [31:0]   sel_addr;
    logic          hit_gpio, hit_uart;
    logic          slv_ready, slv_err;
    logic [31:0]   slv_rdata;
    logic          res_load, res_idx, res_err;
    logic [31:0]   res_rdata;

    // Handshake: reqN_ready is a combinational accept in IDLE; the request is
    // consumed on the rising edge where valid and ready are both high.
    assign req_any   = req0_valid | req1_valid;
    assign gnt_idx   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    assign sel_addr  = gnt_idx ? req1_addr : req0_addr;
    assign hit_gpio  = (sel_addr[31:12] == GPIO_BASE);
    assign hit_uart  = !hit_gpio && (sel_addr[31:12] == UART_BASE);

    // Only the selected slave's response is looked at.
    assign slv_ready = (sel_gpio_q & pready_gpio)  | (sel_uart_q & pready_uart);
    assign slv_err   = (sel_gpio_q & pslverr_gpio) | (sel_uart_q & pslverr_uart);
    assign slv_rdata = sel_gpio_q ? prdata_gpio : prdata_uart;

    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        res_load  = 1'b0;
        res_idx   = gnt_q;
        res_err   = 1'b0;
        res_rdata = '0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant   = 1'b1;
                    res_idx = gnt_idx;
                    if (hit_gpio || hit_uart) begin
                        state_d = SETUP;
                    end else begin
                        state_d  = RESP;
                        res_load = 1'b1;
                        res_err  = 1'b1;
                    end
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (slv_ready) begin
                    state_d   = RESP;
                    res_load  = 1'b1;
                    res_err   = slv_err;
                    res_rdata = pwrite ? '0 : slv_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = RESP;
                    res_load = 1'b1;
                    res_err  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == ACCESS && state_d == ACCESS) ? cnt_q + CW'(1) : '0;
        end
    end

    // last_q resets to 1 so requester 0 wins the first contested grant.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            sel_gpio_q <= 1'b0;
            sel_uart_q <= 1'b0;
            paddr      <= '0;
            pwrite     <= 1'b0;
            pwdata     <= '0;
            pstrb      <= '0;
        end else if (grant) begin
            gnt_q      <= gnt_idx;
            last_q     <= gnt_idx;
            sel_gpio_q <= hit_gpio;
            sel_uart_q <= hit_uart;
            paddr      <= sel_addr;
            pwrite     <= gnt_idx ? req1_write : req0_write;
            pwdata     <= gnt_idx ? req1_wdata : req0_wdata;
            pstrb      <= gnt_idx ? req1_strb  : req0_strb;
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            req0_rdata <= '0;
            req0_err   <= 1'b0;
            req1_rdata <= '0;
            req1_err   <= 1'b0;
        end else if (res_load) begin
            if (res_idx) begin
                req1_rdata <= res_rdata;
                req1_err   <= res_err;
            end else begin
                req0_rdata <= res_rdata;
                req0_err   <= res_err;
            end
        end
    end

    assign req0_ready = rst & grant & ~gnt_idx;
    assign req1_ready = rst & grant & gnt_idx;
    assign req0_done  = (state_q == RESP) & ~gnt_q;
    assign req1_done  = (state_q == RESP) & gnt_q;
    assign psel_gpio  = sel_gpio_q & (state_q == SETUP || state_q == ACCESS);
    assign psel_uart  = sel_uart_q & (state_q == SETUP || state_q == ACCESS);
    assign penable    = (state_q == ACCESS) & (sel_gpio_q | sel_uart_q);
    assign dbg_state  = state_q;

endmodule
